object_table_arbiter: RTL and testbench
=======================================

// Module: object_table_arbiter
// PURPOSE
//  Owns the shared object-state table (NUM_SLOTS records x 5 fields x 11 bits) that the renderer consumes as current_state.
//  Lets several controllers (player, enemy spawner, fuel, HUD) write records into it, one write per cycle, with round-robin arbitration.
//  Accepted writes go to a shadow table. The shadow table is committed atomically to the visible table on frame_start, so the drawer never sees a half-updated frame.
// PARAMETERS
//  NUM_REQ    4   number of requesting controllers
//  NUM_SLOTS  3   object records in the table; visible output is NUM_SLOTS*5 words
// PORTS
//  clk           in   1                  system clock; single clock domain
//  reset         in   1                  synchronous, active-high reset
//  frame_start   in   1                  one-cycle pulse at the start of each video frame
//  freeze        in   1                  1 = block all grants (pause/death); commit still happens
//  req_valid     in   NUM_REQ            requester i holds a write request
//  req_slot      in   NUM_REQ x 4        target slot index per requester
//  req_record    in   NUM_REQ x [0:4][0:10]  record {img_id,x,y,width,height}
//  req_ready     out  NUM_REQ            one-hot grant; transfer = valid & ready
//  table_state   out  [0:NUM_SLOTS*5-1][0:10]  visible table, same layout as current_state
//  slot_dirty    out  NUM_SLOTS          slot written in shadow since last commit
//  commit_pulse  out  1                  high for the cycle after a commit
//  bad_slot_err  out  1                  sticky: a write to slot >= NUM_SLOTS was accepted
// BEHAVIOUR
//  - Reset values: shadow = visible = DEFAULT_TABLE; req_ready=0; slot_dirty=0; commit_pulse=0; bad_slot_err=0; RR pointer=0; FSM=S_RUN.
//  - Reset is synchronous: a request pending when reset rises is dropped; requesters re-present it after reset.
//  - FSM states: S_RUN and S_COMMIT.
//    * S_RUN: if frame_start, go to S_COMMIT; else stay.
//    * S_COMMIT: lasts exactly 1 cycle, then back to S_RUN.
//  - Grant (combinational from registered pointer): req_ready is all-zero when freeze=1, when state=S_COMMIT, or in the frame_start cycle.
//    * Otherwise the first i with req_valid[i], searching from ptr upward mod NUM_REQ, gets ready=1.
//  - On a transfer by requester g, ptr <= (g+1) mod NUM_REQ. With no transfer, ptr holds.
//  - Transfer with req_slot < NUM_SLOTS: shadow[slot] <= req_record and slot_dirty[slot] <= 1. The write is visible in the shadow next cycle.
//  - Transfer with req_slot >= NUM_SLOTS: accepted (ready high) but dropped; bad_slot_err <= 1 until reset.
//  - Commit: in the S_COMMIT cycle, visible <= shadow and slot_dirty <= 0; commit_pulse is 1 in the following cycle.
//    * table_state therefore changes exactly 2 cycles after frame_start and never at any other time.
//  - Same slot written twice in one frame: the last accepted write wins; earlier data is never visible.
//  - frame_start arriving while in S_COMMIT (back-to-back pulses) is ignored; no second commit.
//  - freeze does not inhibit commit; the shadow simply carries no new writes.
//  - Requester contract: req_slot and req_record must be stable while req_valid=1 and ready=0; valid must not drop before transfer.
//  - Only 11-bit fields are stored; no arithmetic on field contents.
// STRUCTURE
//  - Package objects_pkg holds:
//    * FIELD_W=11, NUM_FIELDS=5, field index constants F_IMG/F_X/F_Y/F_W/F_H
//    * typedef obj_record_t = logic [0:4][0:10]
//    * DEFAULT_TABLE: slot0 = {0,272,380,64,64}, all other slots zero
//  - Sub-module rr_arbiter: NUM_REQ-wide, inputs req/enable/advance, outputs one-hot grant and index.
//    Pointer register lives inside rr_arbiter.
//  - Top level holds the FSM, shadow/visible tables, dirty bits and error flag.
// TESTING
//  1. Reset: assert reset 3 cycles -> table_state slot0={0,272,380,64,64}, rest 0; req_ready=0; bad_slot_err=0.
//  2. Fairness: req_valid=4'b1111 held for 8 cycles, no frame_start -> grants in order 0,1,2,3,0,1,2,3.
//  3. Atomic commit: req1 writes slot2 x=300, then frame_start ->
//     * table_state slot2.x stays 0 until 2 cycles after frame_start, then reads 300;
//     * commit_pulse high that same cycle; slot_dirty[2] 1 then 0.
//  4. Collision: req0 writes slot1 img=5, then req3 writes slot1 img=9 in the same frame -> after commit slot1.img=9.
//  5. Bad slot / freeze: req2 slot=7 -> ready asserted, table unchanged, bad_slot_err=1.
//     Then freeze=1 with req0 valid -> no ready for 10 cycles; frame_start still yields commit_pulse.
//  6. Reset mid-operation: reset during S_COMMIT with shadow modified -> visible and shadow return to DEFAULT_TABLE, ptr=0.

Source files
------------

// File: rtl/objects_pkg.sv
// Shared object-record types and the power-on contents of the object-state table.
package objects_pkg;

    localparam int FIELD_W    = 11;
    localparam int NUM_FIELDS = 5;
    localparam int F_IMG      = 0;
    localparam int F_X        = 1;
    localparam int F_Y        = 2;
    localparam int F_W        = 3;
    localparam int F_H        = 4;

    typedef logic [0:NUM_FIELDS-1][0:FIELD_W-1] obj_record_t;

    typedef enum logic {
        S_RUN,
        S_COMMIT
    } state_t;

    localparam obj_record_t DEFAULT_SLOT0 = {11'd0, 11'd272, 11'd380, 11'd64, 11'd64};

    // Slot 0 holds the player sprite at power-on; every other slot starts empty.
    function automatic obj_record_t default_table(input int slot);
        obj_record_t rec;
        rec = '0;
        if (slot == 0) begin
            rec = DEFAULT_SLOT0;
        end
        return rec;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer moves past the winner only when the grant is actually taken.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             enable,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end

        grant = '0;
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end

        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = IDX_W'((int'(grant_idx) + 1) % N);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/object_table_arbiter.sv
// Arbitrates controller writes into a shadow object table and commits it to the visible
// table once per frame, so the renderer only ever sees whole frames.
module object_table_arbiter
    import objects_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_SLOTS = 3
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              frame_start,
    input  logic                                              freeze,
    input  logic        [NUM_REQ-1:0]                         req_valid,
    input  logic        [NUM_REQ-1:0][3:0]                    req_slot,
    input  obj_record_t [NUM_REQ-1:0]                         req_record,
    output logic        [NUM_REQ-1:0]                         req_ready,
    output logic        [0:NUM_SLOTS*NUM_FIELDS-1][0:FIELD_W-1] table_state,
    output logic        [NUM_SLOTS-1:0]                       slot_dirty,
    output logic                                              commit_pulse,
    output logic                                              bad_slot_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state_q;
    state_t               state_d;
    obj_record_t          shadow_q  [NUM_SLOTS];
    obj_record_t          shadow_d  [NUM_SLOTS];
    obj_record_t          visible_q [NUM_SLOTS];
    obj_record_t          visible_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] dirty_q;
    logic [NUM_SLOTS-1:0] dirty_d;
    logic                 commit_q;
    logic                 err_q;
    logic                 err_d;

    logic                 grant_en;
    logic                 xfer;
    logic [IDX_W-1:0]     gnt_idx;
    logic [3:0]           wr_slot;
    obj_record_t          wr_rec;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .enable    (grant_en),
        .advance   (xfer),
        .grant     (req_ready),
        .grant_idx (gnt_idx)
    );

    assign xfer    = |(req_ready & req_valid);
    assign wr_slot = req_slot[gnt_idx];
    assign wr_rec  = req_record[gnt_idx];

    // Grants are withheld on the frame_start cycle so nothing lands in the shadow
    // between the commit decision and the copy.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        case (state_q)
            S_RUN: begin
                grant_en = !freeze && !frame_start;
                if (frame_start) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        shadow_d  = shadow_q;
        visible_d = visible_q;
        dirty_d   = dirty_q;
        err_d     = err_q;

        if (xfer) begin
            if (wr_slot >= 4'(NUM_SLOTS)) begin
                err_d = 1'b1;
            end
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (wr_slot == 4'(s)) begin
                    shadow_d[s] = wr_rec;
                    dirty_d[s]  = 1'b1;
                end
            end
        end

        if (state_q == S_COMMIT) begin
            visible_d = shadow_q;
            dirty_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            dirty_q  <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                shadow_q[s]  <= default_table(s);
                visible_q[s] <= default_table(s);
            end
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            visible_q <= visible_d;
            dirty_q   <= dirty_d;
            commit_q  <= (state_q == S_COMMIT);
            err_q     <= err_d;
        end
    end

    always_comb begin
        table_state = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int f = F_IMG; f <= F_H; f++) begin
                table_state[s*NUM_FIELDS + f] = visible_q[s][f];
            end
        end
    end

    assign slot_dirty   = dirty_q;
    assign commit_pulse = commit_q;
    assign bad_slot_err = err_q;

endmodule

// File: tb/tb_object_table_arbiter.sv
// Directed bench for object_table_arbiter with a frame-level reference model checked every cycle.
module tb_object_table_arbiter;
    import objects_pkg::*;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    frame_start;
    logic                    freeze;
    logic        [3:0]       req_valid;
    logic        [3:0][3:0]  req_slot;
    obj_record_t [3:0]       req_record;
    logic        [3:0]       req_ready;
    logic        [0:14][0:10] table_state;
    logic        [2:0]       slot_dirty;
    logic                    commit_pulse;
    logic                    bad_slot_err;

    int n_tests = 0;
    int n_fail  = 0;

    object_table_arbiter #(.NUM_REQ(4), .NUM_SLOTS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .freeze       (freeze),
        .req_valid    (req_valid),
        .req_slot     (req_slot),
        .req_record   (req_record),
        .req_ready    (req_ready),
        .table_state  (table_state),
        .slot_dirty   (slot_dirty),
        .commit_pulse (commit_pulse),
        .bad_slot_err (bad_slot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obj_record_t mkrec(input int a, input int b, input int c, input int d, input int e);
        obj_record_t r;
        r[0] = 11'(a);
        r[1] = 11'(b);
        r[2] = 11'(c);
        r[3] = 11'(d);
        r[4] = 11'(e);
        return r;
    endfunction

    // Reference model: what the renderer should see, tracked per frame.
    int DEF0 [5] = '{0, 272, 380, 64, 64};
    int m_shadow [3][5];
    int m_vis    [3][5];
    int m_ptr;
    int m_dirty;
    bit m_commit_due;
    bit m_pulse;
    bit m_err;
    bit m_ok = 1'b0;

    always @(negedge clk) begin : model
        int g;
        int v;
        int s;
        int exp_rdy;
        int idx;
        g = -1;
        v = int'(req_valid);
        if (!(freeze || m_commit_due || frame_start)) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (g < 0 && ((v >> idx) & 1) == 1) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (1 << g) : 0;

        if (m_ok) begin
            chk("ready", int'(req_ready), exp_rdy);
            for (int i = 0; i < 15; i++) begin
                idx = i;
                chk($sformatf("table[%0d]", i), int'(table_state[idx[3:0]]), m_vis[i/5][i%5]);
            end
            chk("dirty", int'(slot_dirty), m_dirty);
            chk("commit_pulse", int'(commit_pulse), int'(m_pulse));
            chk("bad_slot_err", int'(bad_slot_err), int'(m_err));
        end

        if (reset) begin
            for (int a = 0; a < 3; a++) begin
                for (int f = 0; f < 5; f++) begin
                    m_shadow[a][f] = (a == 0) ? DEF0[f] : 0;
                    m_vis[a][f]    = (a == 0) ? DEF0[f] : 0;
                end
            end
            m_ptr = 0; m_dirty = 0; m_commit_due = 0; m_pulse = 0; m_err = 0;
            m_ok = 1'b1;
        end else begin
            m_pulse = m_commit_due;
            if (m_commit_due) begin
                m_vis   = m_shadow;
                m_dirty = 0;
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % 4;
                s = int'(req_slot[g[1:0]]);
                if (s < 3) begin
                    for (int f = 0; f < 5; f++) begin
                        idx = f;
                        m_shadow[s][f] = int'(req_record[g[1:0]][idx[2:0]]);
                    end
                    m_dirty = m_dirty | (1 << s);
                end else begin
                    m_err = 1'b1;
                end
            end
            m_commit_due = !m_commit_due && frame_start;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1; frame_start = 1'b0; freeze = 1'b0;
        req_valid = '0; req_slot = '0; req_record = '0;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_img", int'(table_state[0]), 0);
        chk("rst_x", int'(table_state[1]), 272);
        chk("rst_y", int'(table_state[2]), 380);
        chk("rst_w", int'(table_state[3]), 64);
        chk("rst_h", int'(table_state[4]), 64);
        chk("rst_slot2_x", int'(table_state[11]), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_err", int'(bad_slot_err), 0);
        chk("rst_dirty", int'(slot_dirty), 0);
        tick();

        // Fairness: all four requesting
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_slot[i]   = 4'd0;
            req_record[i] = mkrec(i + 1, i, i, i, i);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fair_grant", int'(req_ready), 1 << (k % 4));
            tick();
        end
        req_valid = '0;

        // Atomic commit
        req_valid = 4'b0010; req_slot[1] = 4'd2; req_record[1] = mkrec(0, 300, 0, 0, 0);
        @(negedge clk);
        chk("t3_ready", int'(req_ready), 4'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t3_dirty2", int'(slot_dirty[2]), 1);
        chk("t3_x_pre", int'(table_state[11]), 0);
        tick();
        frame_start = 1'b1;
        @(negedge clk);
        chk("t3_x_fs", int'(table_state[11]), 0);
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        chk("t3_x_fs1", int'(table_state[11]), 0);
        chk("t3_pulse_fs1", int'(commit_pulse), 0);
        tick();
        @(negedge clk);
        chk("t3_x_fs2", int'(table_state[11]), 300);
        chk("t3_pulse_fs2", int'(commit_pulse), 1);
        chk("t3_dirty2_clr", int'(slot_dirty[2]), 0);
        tick();

        // Collision: last write in a frame wins
        req_valid = 4'b0001; req_slot[0] = 4'd1; req_record[0] = mkrec(5, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_ready0", int'(req_ready), 4'b0001);
        tick();
        req_valid = 4'b1000; req_slot[3] = 4'd1; req_record[3] = mkrec(9, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_ready3", int'(req_ready), 4'b1000);
        chk("t4_img_pre", int'(table_state[5]), 0);
        tick();
        req_valid = '0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_img_post", int'(table_state[5]), 9);
        tick();

        // Bad slot, then freeze
        req_valid = 4'b0100; req_slot[2] = 4'd7; req_record[2] = mkrec(1, 2, 3, 4, 5);
        @(negedge clk);
        chk("t5_ready", int'(req_ready), 4'b0100);
        chk("t5_err_pre", int'(bad_slot_err), 0);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t5_err", int'(bad_slot_err), 1);
        tick();
        freeze = 1'b1; req_valid = 4'b0001; req_slot[0] = 4'd0; req_record[0] = mkrec(7, 7, 7, 7, 7);
        for (int k = 0; k < 10; k++) begin
            frame_start = (k == 3);
            @(negedge clk);
            chk("t5_frz_ready", int'(req_ready), 0);
            if (k == 5) chk("t5_frz_pulse", int'(commit_pulse), 1);
            tick();
        end
        frame_start = 1'b0; freeze = 1'b0;
        @(negedge clk);
        chk("t5_unfrz_ready", int'(req_ready), 4'b0001);
        chk("t5_err_sticky", int'(bad_slot_err), 1);
        tick();
        req_valid = '0;

        // Reset while committing a modified shadow
        req_valid = 4'b0010; req_slot[1] = 4'd0; req_record[1] = mkrec(11, 22, 33, 44, 55);
        @(negedge clk);
        chk("t6_ready", int'(req_ready), 4'b0010);
        tick();
        req_valid = '0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_img", int'(table_state[0]), 0);
        chk("t6_x", int'(table_state[1]), 272);
        chk("t6_pulse", int'(commit_pulse), 0);
        chk("t6_err", int'(bad_slot_err), 0);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_shadow_x", int'(table_state[1]), 272);
        chk("t6_shadow_h", int'(table_state[4]), 64);
        tick();
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) req_slot[i] = 4'd1;
        @(negedge clk);
        chk("t6_ptr0", int'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
